addr_walker: RTL and testbench
==============================

# addr_walker

Parametrised successor to the single-register address counter used by the matrix-multiplication cores. It keeps the manual load/increment/stride-increment/clear command set, now with a runtime-loadable stride. It adds an autonomous 2-D walk mode that emits a rows×cols sub-matrix address sequence with a start/busy/done handshake. It sits between a core's controller and its operand memory read port.

## Interface

**Parameters**
- WIDTH, 16: address width; all address arithmetic is modulo 2^WIDTH.
- CNT_WIDTH, 16: width of the rows/cols counters.
- K_DEFAULT, 16'd100: stride register value after reset.

**Ports**
- clk, input, 1: single clock; all state updates on the rising edge.
- reset, input, 1: asynchronous, active-high reset.
- clear, input, 1: synchronous clear; data_out←0 and any walk is aborted.
- load_enable, input, 1: data_out←data_in.
- data_in, input, WIDTH: load value.
- inc, input, 1: data_out←data_out+1.
- inck, input, 1: data_out←data_out+k.
- k_load, input, 1: k←k_in.
- k_in, input, WIDTH: new stride.
- start, input, 1: begin a 2-D walk from the current data_out.
- rows, input, CNT_WIDTH: walk row count; sampled at start.
- cols, input, CNT_WIDTH: walk column count; sampled at start.
- data_out, output, WIDTH: current address.
- valid, output, 1: data_out is a walk address this cycle.
- busy, output, 1: high while in WALK.
- done, output, 1: one-cycle pulse at walk completion.

## Operation

- **Reset values:** data_out=0, k=K_DEFAULT, state=IDLE, valid=0, busy=0, done=0. Internal row_base, row_cnt and col_cnt are all 0.
- **States:** IDLE, WALK, DONE.
- **IDLE:** one action per edge, in this priority order: clear > start > inck > inc > load_enable. Lower-priority requests in the same cycle are dropped.
- **start in IDLE:**
  - Latch rows, cols and row_base←data_out. Clear row_cnt and col_cnt.
  - Go to WALK. If rows==0 or cols==0, go to DONE instead.
- **WALK:**
  - valid=1 and busy=1 every cycle.
  - At each edge:
    - **Last element** (row_cnt==rows−1 and col_cnt==cols−1): go to DONE. data_out holds the last address.
    - **End of row** (col_cnt==cols−1): row_base←row_base+k, data_out←row_base+k, col_cnt←0, row_cnt++.
    - **Otherwise:** data_out←data_out+1, col_cnt++.
  - inc, inck, load_enable and start are ignored.
  - clear aborts to IDLE with data_out←0 and no done pulse.
- **DONE:** done=1, valid=0, busy=0 for exactly one cycle, then IDLE. Commands are ignored, except that clear still zeroes data_out.
- **k_load:** honoured in any state. In WALK the new k is used from the next row transition on.
- **Wrap-around:** all sums are truncated to WIDTH bits with no flag. Counters cannot overflow because they stop at rows−1 and cols−1.
- **Asynchronous reset mid-walk:** immediate return to the reset values; no done pulse.

## Timing

- Manual commands and k_load take effect on the edge where they are sampled; data_out updates the following cycle.
- start sampled at edge n: WALK from cycle n+1. The first valid address, equal to data_out at edge n, is in cycle n+1.
- A walk gives exactly rows×cols consecutive valid cycles, one address per cycle, with no bubbles at row transitions.
- done is asserted in the cycle immediately after the last valid cycle. start is accepted again from the cycle after done.
- Zero-dimension start: done one cycle after start, with no valid cycles.
- Outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.

## Test plan

1. **Reset defaults:** assert reset asynchronously mid-cycle. Outputs go to 0 immediately. inck then gives data_out=100, confirming k=100.
2. **Manual priority:** load 0x0040, then inc and inck together → 0x00A4 (inck wins). Next, inc+load_enable(0x1234) → 0x00A5. Next, clear+inck → 0x0000.
3. **Basic walk:** data_out=0x0010, k_load 8, rows=2, cols=3, start. Valid sequence is 0x10, 0x11, 0x12, 0x18, 0x19, 0x1A, then a single done pulse. data_out stays 0x1A; busy is high for 6 cycles.
4. **Wrap:** data_out=0xFFFE, inc ×3 → 0xFFFF, 0x0000, 0x0001. Walk from 0xFFFF with k=2, rows=2, cols=2 → 0xFFFF, 0x0000, 0x0001, 0x0002.
5. **Abort and mid-walk k change:** clear in the 3rd valid cycle of a 3×4 walk → next cycle data_out=0, busy=0, valid=0, no done. Separately, k_load 16 during row 0 of a k=4 walk: the row-1 base is row0_base+16.
6. **Zero dimension and reset:** rows=0, start → done next cycle, no valid cycles, data_out unchanged. Asynchronous reset during WALK → IDLE, data_out=0, k=100, no done pulse.

Source files
------------

// File: rtl/addr_walker.sv
// Address counter for the matmul cores: manual load/inc/stride/clear commands plus
// an autonomous rows x cols sub-matrix walk with a start/busy/done handshake.
module addr_walker #(
    parameter int               WIDTH     = 16,
    parameter int               CNT_WIDTH = 16,
    parameter logic [WIDTH-1:0] K_DEFAULT = WIDTH'(100)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 load_enable,
    input  logic [WIDTH-1:0]     data_in,
    input  logic                 inc,
    input  logic                 inck,
    input  logic                 k_load,
    input  logic [WIDTH-1:0]     k_in,
    input  logic                 start,
    input  logic [CNT_WIDTH-1:0] rows,
    input  logic [CNT_WIDTH-1:0] cols,
    output logic [WIDTH-1:0]     data_out,
    output logic                 valid,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WALK = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               state_r, state_s;
    logic [WIDTH-1:0]     data_r, data_s;
    logic [WIDTH-1:0]     k_r, k_s;
    logic [WIDTH-1:0]     row_base_r, row_base_s;
    logic [CNT_WIDTH-1:0] row_cnt_r, row_cnt_s;
    logic [CNT_WIDTH-1:0] col_cnt_r, col_cnt_s;
    logic [CNT_WIDTH-1:0] rows_r, rows_s;
    logic [CNT_WIDTH-1:0] cols_r, cols_s;
    logic                 row_last_s;
    logic                 col_last_s;

    assign row_last_s = (row_cnt_r == (rows_r - CNT_WIDTH'(1)));
    assign col_last_s = (col_cnt_r == (cols_r - CNT_WIDTH'(1)));

    // Outputs are the address register and a decode of the state register only.
    assign data_out = data_r;
    assign valid    = (state_r == ST_WALK);
    assign busy     = (state_r == ST_WALK);
    assign done     = (state_r == ST_DONE);

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            data_r     <= {WIDTH{1'b0}};
            k_r        <= K_DEFAULT;
            row_base_r <= {WIDTH{1'b0}};
            row_cnt_r  <= {CNT_WIDTH{1'b0}};
            col_cnt_r  <= {CNT_WIDTH{1'b0}};
            rows_r     <= {CNT_WIDTH{1'b0}};
            cols_r     <= {CNT_WIDTH{1'b0}};
        end else begin
            state_r    <= state_s;
            data_r     <= data_s;
            k_r        <= k_s;
            row_base_r <= row_base_s;
            row_cnt_r  <= row_cnt_s;
            col_cnt_r  <= col_cnt_s;
            rows_r     <= rows_s;
            cols_r     <= cols_s;
        end
    end

    // Next-state and datapath decode.
    always_comb begin
        state_s    = state_r;
        data_s     = data_r;
        k_s        = k_r;
        row_base_s = row_base_r;
        row_cnt_s  = row_cnt_r;
        col_cnt_s  = col_cnt_r;
        rows_s     = rows_r;
        cols_s     = cols_r;

        // The stride is independent of the FSM; a row transition on this edge still sees the old k.
        if (k_load) begin
            k_s = k_in;
        end else begin
            k_s = k_r;
        end

        case (state_r)
            ST_IDLE: begin
                if (clear) begin
                    data_s = {WIDTH{1'b0}};
                end else if (start) begin
                    rows_s     = rows;
                    cols_s     = cols;
                    row_base_s = data_r;
                    row_cnt_s  = {CNT_WIDTH{1'b0}};
                    col_cnt_s  = {CNT_WIDTH{1'b0}};
                    if ((rows == {CNT_WIDTH{1'b0}}) || (cols == {CNT_WIDTH{1'b0}})) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_WALK;
                    end
                end else if (inck) begin
                    data_s = data_r + k_r;
                end else if (inc) begin
                    data_s = data_r + WIDTH'(1);
                end else if (load_enable) begin
                    data_s = data_in;
                end else begin
                    data_s = data_r;
                end
            end
            ST_WALK: begin
                if (clear) begin
                    state_s = ST_IDLE;
                    data_s  = {WIDTH{1'b0}};
                end else if (row_last_s && col_last_s) begin
                    state_s = ST_DONE;
                end else if (col_last_s) begin
                    row_base_s = row_base_r + k_r;
                    data_s     = row_base_r + k_r;
                    col_cnt_s  = {CNT_WIDTH{1'b0}};
                    row_cnt_s  = row_cnt_r + CNT_WIDTH'(1);
                end else begin
                    data_s    = data_r + WIDTH'(1);
                    col_cnt_s = col_cnt_r + CNT_WIDTH'(1);
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
                if (clear) begin
                    data_s = {WIDTH{1'b0}};
                end else begin
                    data_s = data_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_addr_walker.sv
// Randomised self-checking bench for addr_walker against an arithmetic reference model.
module tb_addr_walker;

    logic        clk;
    logic        reset;
    logic        clear;
    logic        load_enable;
    logic [15:0] data_in;
    logic        inc;
    logic        inck;
    logic        k_load;
    logic [15:0] k_in;
    logic        start;
    logic [15:0] rows;
    logic [15:0] cols;
    logic [15:0] data_out;
    logic        valid;
    logic        busy;
    logic        done;

    int errors_r = 0;
    int checks_r = 0;

    // Reference model state: current address and stride.
    logic [15:0] m_addr;
    logic [15:0] m_k;

    addr_walker dut (
        .clk(clk), .reset(reset), .clear(clear), .load_enable(load_enable),
        .data_in(data_in), .inc(inc), .inck(inck), .k_load(k_load), .k_in(k_in),
        .start(start), .rows(rows), .cols(cols), .data_out(data_out),
        .valid(valid), .busy(busy), .done(done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks_r++;
        if (obs !== exp_v) begin
            errors_r++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        clear = 1'b0; load_enable = 1'b0; inc = 1'b0; inck = 1'b0;
        k_load = 1'b0; start = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check_val({tag, "_addr"}, data_out, m_addr);
        check_val({tag, "_flags"}, {valid, busy, done}, 3'b000);
    endtask

    // One manual command cycle; the model applies the priority rule with the old stride.
    task automatic manual_op(input logic c, input logic ik, input logic i, input logic ld,
                             input logic [15:0] din, input logic kl, input logic [15:0] kin);
        clear = c; inck = ik; inc = i; load_enable = ld; data_in = din;
        k_load = kl; k_in = kin;
        step();
        idle_inputs();
        if (c) m_addr = 16'h0000;
        else if (ik) m_addr = m_addr + m_k;
        else if (i) m_addr = m_addr + 16'h0001;
        else if (ld) m_addr = din;
        else m_addr = m_addr;
        if (kl) m_k = kin;
        check_idle("manual");
    endtask

    task automatic async_reset(input string tag);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        m_addr = 16'h0000;
        m_k    = 16'd100;
        check_val({tag, "_addr"}, data_out, 16'h0000);
        check_val({tag, "_flags"}, {valid, busy, done}, 3'b000);
        @(negedge clk);
        reset = 1'b0;
        step();
        check_val({tag, "_nodone"}, done, 1'b0);
    endtask

    // Full walk from the model address; garbage commands are thrown in and must be ignored.
    task automatic run_walk(input int nr, input int nc);
        logic [15:0] base;
        logic [15:0] exp_a;
        base = m_addr;
        rows = 16'(nr); cols = 16'(nc); start = 1'b1;
        step();
        idle_inputs();
        if (nr == 0 || nc == 0) begin
            check_val("zero_done", {valid, busy, done}, 3'b001);
            check_val("zero_addr", data_out, base);
            step();
            check_idle("zero_after");
        end else begin
            for (int r = 0; r < nr; r++) begin
                for (int c = 0; c < nc; c++) begin
                    exp_a = 16'(int'(base) + r * int'(m_k) + c);
                    check_val("walk_addr", data_out, exp_a);
                    check_val("walk_flags", {valid, busy, done}, 3'b110);
                    inc = 1'($urandom); inck = 1'($urandom);
                    load_enable = 1'($urandom); start = 1'($urandom);
                    data_in = 16'($urandom);
                    step();
                end
            end
            m_addr = 16'(int'(base) + (nr - 1) * int'(m_k) + nc - 1);
            idle_inputs();
            check_val("done_flags", {valid, busy, done}, 3'b001);
            check_val("done_addr", data_out, m_addr);
            start = 1'b1; inck = 1'b1;
            step();
            idle_inputs();
            check_idle("after_done");
        end
    endtask

    initial begin
        reset = 1'b1; data_in = 16'h0000; k_in = 16'h0000;
        rows = 16'h0000; cols = 16'h0000;
        idle_inputs();
        m_addr = 16'h0000; m_k = 16'd100;
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset");
        @(negedge clk);
        reset = 1'b0;
        step();

        // Reset defaults and stride default
        manual_op(1'b0, 1'b0, 1'b0, 1'b1, 16'h5555, 1'b1, 16'd7);
        async_reset("reset_mid");
        manual_op(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
        check_val("k_default", data_out, 16'd100);

        // Manual priority
        manual_op(1'b0, 1'b0, 1'b0, 1'b1, 16'h0040, 1'b0, 16'h0000);
        manual_op(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000);
        check_val("prio_inck", data_out, 16'h00A4);
        manual_op(1'b0, 1'b0, 1'b1, 1'b1, 16'h1234, 1'b0, 16'h0000);
        check_val("prio_inc", data_out, 16'h00A5);
        manual_op(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
        check_val("prio_clear", data_out, 16'h0000);

        // Basic walk 2x3 from 0x10 with k=8
        manual_op(1'b0, 1'b0, 1'b0, 1'b1, 16'h0010, 1'b1, 16'd8);
        run_walk(2, 3);
        check_val("basic_last", data_out, 16'h001A);

        // Wrap-around
        manual_op(1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFE, 1'b1, 16'd2);
        manual_op(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000);
        check_val("wrap_ffff", data_out, 16'hFFFF);
        run_walk(2, 2);
        check_val("wrap_walk_last", data_out, 16'h0002);
        manual_op(1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFE, 1'b0, 16'h0000);
        manual_op(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000);
        manual_op(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000);
        check_val("wrap_0000", data_out, 16'h0000);
        manual_op(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000);
        check_val("wrap_0001", data_out, 16'h0001);

        // Abort with clear in the 3rd valid cycle of a 3x4 walk
        manual_op(1'b0, 1'b0, 1'b0, 1'b1, 16'h0200, 1'b1, 16'd4);
        rows = 16'd3; cols = 16'd4; start = 1'b1;
        step();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            check_val("abort_addr", data_out, 16'(16'h0200 + i));
            check_val("abort_busy", busy, 1'b1);
            if (i == 2) clear = 1'b1;
            else step();
        end
        step();
        idle_inputs();
        m_addr = 16'h0000;
        check_idle("abort");
        step();
        check_val("abort_nodone", done, 1'b0);

        // Stride change during row 0 of a k=4 walk
        manual_op(1'b0, 1'b0, 1'b0, 1'b1, 16'h0100, 1'b0, 16'h0000);
        rows = 16'd2; cols = 16'd3; start = 1'b1;
        step();
        idle_inputs();
        for (int i = 0; i < 6; i++) begin
            check_val("kchg_addr", data_out, (i < 3) ? 16'(16'h0100 + i) : 16'(16'h0110 + i - 3));
            check_val("kchg_valid", valid, 1'b1);
            if (i == 0) begin
                k_load = 1'b1; k_in = 16'd16;
            end else begin
                k_load = 1'b0;
            end
            step();
        end
        k_load = 1'b0;
        check_val("kchg_done", done, 1'b1);
        m_addr = 16'h0112; m_k = 16'd16;
        step();
        check_idle("kchg_after");

        // Zero dimensions
        rows = 16'd0; cols = 16'd5;
        run_walk(0, 5);
        run_walk(3, 0);

        // Asynchronous reset during a walk
        manual_op(1'b0, 1'b0, 1'b0, 1'b1, 16'h0300, 1'b1, 16'd9);
        rows = 16'd2; cols = 16'd5; start = 1'b1;
        step();
        idle_inputs();
        step();
        async_reset("reset_walk");
        check_val("reset_walk_idle", {valid, busy}, 2'b00);
        manual_op(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
        check_val("reset_walk_k", data_out, 16'd100);

        // Randomised mix of manual commands and walks
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                run_walk(int'($urandom_range(0, 3)), int'($urandom_range(0, 4)));
            end else begin
                manual_op(($urandom_range(0, 7) == 0), 1'($urandom), 1'($urandom),
                          1'($urandom), 16'($urandom), 1'($urandom), 16'($urandom));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors_r, checks_r);
        $finish;
    end

endmodule
